// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The bench or top level drives the master side; the converter is the slave.
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  Start;
  logic [WIDTH-1:0]      Bin;
  logic                  Ready;
  logic                  Done;
  logic [4*DIGITS-1:0]   Digits;
  logic [DIGITS-1:0]     Blank;
  logic                  Overflow;

  modport master (
    output Start, Bin,
    input  Ready, Done, Digits, Blank, Overflow
  );

  modport slave (
    input  Start, Bin,
    output Ready, Done, Digits, Blank, Overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Double-dabble binary to packed BCD, one shift per cycle.
// Results are held between conversions and carry a leading-zero blank mask.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic           Clk,
  input logic           ResetN,
  bin_to_bcd_seq_if.slave bus
);

  localparam int AW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] RST_BLANK = ~DIGITS'(1);

  typedef enum logic {
    S_IDLE,
    S_CONVERT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_sh;
  logic [AW-1:0]     r_acc;
  logic              r_ovf;

  logic [AW-1:0]     r_digits;
  logic [DIGITS-1:0] r_blank;
  logic              r_ovf_out;
  logic              r_done;

  logic [AW-1:0]     w_adj;
  logic [AW-1:0]     w_acc_nx;
  logic [WIDTH-1:0]  w_sh_nx;
  logic              w_ovf_nx;
  logic [DIGITS-1:0] w_blank;
  logic              w_run;
  logic              w_accept;
  logic              w_last;

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5)
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  // The adjusted accumulator's top bit is what falls off on the shift.
  assign {w_acc_nx, w_sh_nx} = {w_adj[AW-2:0], r_sh, 1'b0};
  assign w_ovf_nx = r_ovf | w_adj[AW-1];

  always_comb begin
    w_blank = '0;
    w_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_run      = w_run & (w_acc_nx[4*i +: 4] == 4'd0);
      w_blank[i] = w_run;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (bus.Start) begin
          w_accept   = 1'b1;
          w_state_nx = S_CONVERT;
        end
      end
      (r_state == S_CONVERT): begin
        if (r_cnt == CW'(1)) begin
          w_last     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt     <= '0;
      r_sh      <= '0;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_digits  <= '0;
      r_blank   <= RST_BLANK;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sh  <= bus.Bin;
        r_acc <= '0;
        r_ovf <= 1'b0;
        r_cnt <= CW'(WIDTH);
      end else if (r_state == S_CONVERT) begin
        r_sh  <= w_sh_nx;
        r_acc <= w_acc_nx;
        r_ovf <= w_ovf_nx;
        r_cnt <= r_cnt - CW'(1);
        if (w_last) begin
          r_digits  <= w_acc_nx;
          r_blank   <= w_blank;
          r_ovf_out <= w_ovf_nx;
          r_done    <= 1'b1;
        end
      end
    end
  end

  assign bus.Ready    = (r_state == S_IDLE);
  assign bus.Done     = r_done;
  assign bus.Digits   = r_digits;
  assign bus.Blank    = r_blank;
  assign bus.Overflow = r_ovf_out;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench: a 3-digit and a 2-digit converter share one stimulus stream and
// are checked every cycle against an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  localparam int W = 8;

  logic         Clk;
  logic         ResetN;
  logic         start;
  logic [W-1:0] bin;
  logic         chk_on;
  int           n_cmp;
  int           n_bad;
  int           cyc;

  bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(3)) if1 ();
  bin_to_bcd_seq_if #(.WIDTH(W), .DIGITS(2)) if2 ();

  assign if1.Start = start;
  assign if1.Bin   = bin;
  assign if2.Start = start;
  assign if2.Bin   = bin;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(3)) u1 (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (if1)
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(2)) u2 (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (if2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int pw10(input int d);
    int p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [11:0] bcd(input int v, input int d);
    logic [11:0] r = '0;
    int m = v % pw10(d);
    for (int i = 0; i < d; i++)
      r[4*i +: 4] = 4'((m / pw10(i)) % 10);
    return r;
  endfunction

  function automatic logic [2:0] blk(input int v, input int d);
    logic [2:0] r = '0;
    int m = v % pw10(d);
    for (int i = 1; i < d; i++)
      r[i] = (m < pw10(i));
    return r;
  endfunction

  // Timing model: a request occupies WIDTH edges, then its value shows.
  int  m_rem;
  int  m_cap;
  int  m_val;
  bit  m_done;

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      m_rem  = 0;
      m_cap  = 0;
      m_val  = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem != 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_val  = m_cap;
          m_done = 1;
        end
      end else if (start) begin
        m_cap = int'(bin);
        m_rem = W;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      chk("dut3_outs",
          32'({if1.Ready, if1.Done, if1.Overflow,
               if1.Blank, if1.Digits}),
          32'({m_rem == 0, m_done, m_val >= 1000,
               blk(m_val, 3), bcd(m_val, 3)}));
      chk("dut2_outs",
          32'({if2.Ready, if2.Done, if2.Overflow,
               if2.Blank, if2.Digits}),
          32'({m_rem == 0, m_done, m_val >= 100,
               blk(m_val, 2)[1:0], bcd(m_val, 2)[7:0]}));
    end
  end

  task automatic run_conv(input logic [W-1:0] v, output int lat);
    int busy_hi = 0;
    @(posedge Clk); #1;
    start = 1'b1;
    bin   = v;
    @(posedge Clk); #1;
    start = 1'b0;
    bin   = W'($urandom);
    lat   = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      if (if1.Done) begin
        lat = n;
        break;
      end
      if (if1.Ready) busy_hi++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("ready_low_busy", 32'(busy_hi), 32'd0);
  endtask

  int lat;
  int dn;
  int t1;
  int t2;

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    cyc    = 0;
    chk_on = 1'b0;
    start  = 1'b0;
    bin    = '0;
    ResetN = 1'b1;
    #2 ResetN = 1'b0;
    #1;
    chk("rst_vals",
        32'({if1.Ready, if1.Done, if1.Overflow,
             if1.Blank, if1.Digits}),
        32'({1'b1, 1'b0, 1'b0, 3'b110, 12'h000}));
    repeat (2) @(posedge Clk);
    #1 ResetN = 1'b1;
    chk_on = 1'b1;

    run_conv(8'd255, lat);
    chk("d255", 32'(if1.Digits), 32'h255);
    chk("b255", 32'(if1.Blank), 32'b000);
    chk("o255", 32'(if1.Overflow), 32'd0);
    run_conv(8'd0, lat);
    chk("d0", 32'({if1.Blank, if1.Digits}), 32'h6000);
    run_conv(8'd7, lat);
    chk("d7", 32'({if1.Blank, if1.Digits}), 32'h6007);
    run_conv(8'd100, lat);
    chk("d100", 32'({if1.Blank, if1.Digits}), 32'h0100);
    run_conv(8'd42, lat);
    chk("b42", 32'(if1.Blank), 32'b100);

    // Busy rejection: a second Start lands mid-conversion and is dropped.
    @(posedge Clk); #1;
    start = 1'b1;
    bin   = 8'd199;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    start = 1'b1;
    bin   = 8'd5;
    repeat (3) @(posedge Clk);
    #1 start = 1'b0;
    dn = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge Clk);
      if (if1.Done) begin
        dn++;
        chk("busy_d199", 32'(if1.Digits), 32'h199);
      end
    end
    chk("busy_dones", 32'(dn), 32'd1);

    // Back-to-back with Start held; new Bin shown in the Done cycle.
    @(posedge Clk); #1;
    start = 1'b1;
    bin   = 8'd42;
    t1 = -1;
    t2 = -1;
    for (int n = 0; n < 40 && t2 < 0; n++) begin
      @(negedge Clk);
      if (if1.Done) begin
        if (t1 < 0) begin
          t1 = cyc;
          chk("b2b_first", 32'(if1.Digits), 32'h042);
          bin = 8'd199;
          @(posedge Clk); #1;
          start = 1'b0;
        end else begin
          t2 = cyc;
          chk("b2b_second", 32'(if1.Digits), 32'h199);
        end
      end
    end
    start = 1'b0;
    chk("b2b_gap", 32'(t2 - t1), 32'(W + 1));

    // Reset in the middle of a conversion.
    @(posedge Clk); #1;
    start = 1'b1;
    bin   = 8'd255;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (4) @(posedge Clk);
    #3 ResetN = 1'b0;
    #1;
    chk("rst_mid",
        32'({if1.Ready, if1.Done, if1.Overflow,
             if1.Blank, if1.Digits}),
        32'({1'b1, 1'b0, 1'b0, 3'b110, 12'h000}));
    @(posedge Clk); #1 ResetN = 1'b1;
    dn = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge Clk);
      if (if1.Done) dn++;
    end
    chk("rst_no_done", 32'(dn), 32'd0);
    run_conv(8'd31, lat);
    chk("d31", 32'({if1.Blank, if1.Digits}), 32'h4031);

    // Two-digit instance truncation.
    run_conv(8'd150, lat);
    chk("ovf150",
        32'({if2.Overflow, if2.Blank, if2.Digits}),
        32'({1'b1, 2'b00, 8'h50}));
    run_conv(8'd99, lat);
    chk("ovf99",
        32'({if2.Overflow, if2.Digits}),
        32'({1'b0, 8'h99}));

    // Random traffic, checked by the per-cycle model compare.
    for (int n = 0; n < 600; n++) begin
      @(posedge Clk); #1;
      start = ($urandom_range(0, 3) == 0);
      bin   = W'($urandom);
    end
    start = 1'b0;
    repeat (12) @(posedge Clk);
    @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
